tag_nios_sysid_arbiter: RTL and testbench



---
 rtl/tag_nios_sysid_pkg.sv | 14 +
 rtl/tag_nios_rr_arb2.sv | 39 +++
 rtl/tag_nios_sysid_arbiter.sv | 96 +++++++++
 tb/tb_tag_nios_sysid_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_nios_sysid_pkg.sv
// rtl/tag_nios_sysid_pkg.sv - shared types and constants for the sysid arbiter
package tag_nios_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   SYSID_DATA_W  = 32;

endpackage

// File: rtl/tag_nios_rr_arb2.sv
// rtl/tag_nios_rr_arb2.sv - 2-way round-robin grant with last-grant pointer
module tag_nios_rr_arb2
  import tag_nios_sysid_pkg::*;
#(
  parameter logic INIT_LAST = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_valid,
  output logic       o_gnt
);

  logic r_last;
  logic w_gnt;

  // On a tie the master that did not win last time gets the slave.
  always_comb begin
    w_gnt = 1'b0;
    if (i_req == 2'b11) begin
      w_gnt = ~r_last;
    end else if (i_req[1]) begin
      w_gnt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last <= INIT_LAST;
    end else if (i_update && (|i_req)) begin
      r_last <= w_gnt;
    end
  end

  assign o_valid = |i_req;
  assign o_gnt   = w_gnt;

endmodule

// File: rtl/tag_nios_sysid_arbiter.sv
// rtl/tag_nios_sysid_arbiter.sv - shares the sysid slave between two read-only masters
module tag_nios_sysid_arbiter
  import tag_nios_sysid_pkg::*;
#(
  parameter int   DATA_W    = SYSID_DATA_W,
  parameter logic INIT_LAST = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt;
  logic              r_s_address;
  logic [DATA_W-1:0] r_m0_data;
  logic [DATA_W-1:0] r_m1_data;

  logic              w_idle;
  logic [1:0]        w_req;
  logic              w_arb_valid;
  logic              w_arb_gnt;
  logic              w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_req    = w_idle ? {m1_read, m0_read} : 2'b00;
  assign w_accept = w_idle & w_arb_valid;

  tag_nios_rr_arb2 #(
    .INIT_LAST (INIT_LAST)
  ) u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_update (w_accept),
    .o_valid  (w_arb_valid),
    .o_gnt    (w_arb_gnt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Each master keeps its own response register so the other side's data never moves.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_s_address <= 1'b0;
      r_m0_data   <= '0;
      r_m1_data   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt       <= w_arb_gnt;
        r_s_address <= w_arb_gnt ? m1_address : m0_address;
      end
      if (r_state == CAPTURE) begin
        if (r_gnt) begin
          r_m1_data <= s_readdata;
        end else begin
          r_m0_data <= s_readdata;
        end
      end
    end
  end

  assign m0_waitrequest   = ~(reset_n & w_accept & ~w_arb_gnt);
  assign m1_waitrequest   = ~(reset_n & w_accept &  w_arb_gnt);
  assign m0_readdatavalid = (r_state == RESP) & ~r_gnt;
  assign m1_readdatavalid = (r_state == RESP) &  r_gnt;
  assign m0_readdata      = r_m0_data;
  assign m1_readdata      = r_m1_data;
  assign s_address        = r_s_address;
  assign busy             = ~w_idle;

endmodule

// File: tb/tb_tag_nios_sysid_arbiter.sv
// tb/tb_tag_nios_sysid_arbiter.sv - scoreboard bench for the sysid arbiter
module tb_tag_nios_sysid_arbiter;
  import tag_nios_sysid_pkg::*;

  localparam logic [31:0] ID_WORD = 32'h6074_2B52;
  localparam logic [31:0] TS_WORD = 32'h5A3C_0F91;

  logic        clock;
  logic        reset_n;
  logic        m0_read, m0_address, m0_waitrequest, m0_readdatavalid;
  logic        m1_read, m1_address, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_address, busy;

  typedef struct {
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mdl0       = '0;
  logic [31:0] mdl1       = '0;

  tag_nios_sysid_arbiter #(
    .DATA_W    (32),
    .INIT_LAST (1'b1)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_readdata       (s_readdata),
    .busy             (busy)
  );

  assign s_readdata = (s_address == SYSID_ADDR_TS) ? TS_WORD : ID_WORD;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      mdl0 = '0;
      mdl1 = '0;
    end else if (m0_readdatavalid || m1_readdatavalid) begin
      if (m0_readdatavalid && m1_readdatavalid) begin
        compared++;
        mismatched++;
        $display("FAIL dual_valid: got both valids expected one");
      end else if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got m%0d valid expected none", m1_readdatavalid);
      end else begin
        e = exp_q.pop_front();
        chk("resp_master", {31'd0, m1_readdatavalid}, {31'd0, e.m});
        if (e.m) begin
          mdl1 = e.d;
          chk("m1_readdata", m1_readdata, mdl1);
          chk("m0_readdata_held", m0_readdata, mdl0);
        end else begin
          mdl0 = e.d;
          chk("m0_readdata", m0_readdata, mdl0);
          chk("m1_readdata_held", m1_readdata, mdl1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    m0_read    = 1'b1;
    m0_address = 1'b0;
    m1_read    = 1'b0;
    m1_address = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_valid", m0_readdatavalid, 0);
    chk("rst_m1_valid", m1_readdatavalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_data", m0_readdata, 0);
    chk("rst_m1_data", m1_readdata, 0);
    chk("rst_s_address", s_address, 0);

    step();
    reset_n = 1'b1;
    m0_read = 1'b0;
    step();

    // single read from m0
    m0_read = 1'b1;
    m0_address = SYSID_ADDR_ID;
    push(1'b0, ID_WORD);
    @(negedge clock);
    chk("single_m0_wait_T", m0_waitrequest, 0);
    chk("single_m1_wait_T", m1_waitrequest, 1);
    step();
    m0_read = 1'b0;
    @(negedge clock);
    chk("single_busy_T1", busy, 1);
    chk("single_saddr_T1", s_address, 0);
    chk("single_valid_T1", m0_readdatavalid, 0);
    chk("single_m0_wait_T1", m0_waitrequest, 1);
    step();
    @(negedge clock);
    chk("single_valid_T2", m0_readdatavalid, 1);
    step();
    @(negedge clock);
    chk("single_busy_T3", busy, 0);
    chk("single_valid_T3", m0_readdatavalid, 0);

    // fresh pointer so m0 wins the first tie
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // contention
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b1;
    push(1'b0, ID_WORD);
    push(1'b1, TS_WORD);
    @(negedge clock);
    chk("cont_m0_wait_T", m0_waitrequest, 0);
    chk("cont_m1_wait_T", m1_waitrequest, 1);
    step();
    @(negedge clock);
    chk("cont_saddr_T1", s_address, 0);
    chk("cont_m1_wait_T1", m1_waitrequest, 1);
    step();
    @(negedge clock);
    chk("cont_m0_valid_T2", m0_readdatavalid, 1);
    step();
    @(negedge clock);
    chk("cont_m1_wait_T3", m1_waitrequest, 0);
    chk("cont_m0_wait_T3", m0_waitrequest, 1);
    step();
    m0_read = 1'b0;
    m1_read = 1'b0;
    @(negedge clock);
    chk("cont_saddr_T4", s_address, 1);
    step();
    @(negedge clock);
    chk("cont_m1_valid_T5", m1_readdatavalid, 1);
    step();

    // fairness: pointer now says m1 was last, so m0 leads
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    push(1'b0, TS_WORD);
    push(1'b1, ID_WORD);
    push(1'b0, TS_WORD);
    push(1'b1, ID_WORD);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k % 3 == 0) begin
        chk($sformatf("fair_m0_wait_%0d", k), m0_waitrequest, ((k / 3) % 2));
        chk($sformatf("fair_m1_wait_%0d", k), m1_waitrequest, 1 - ((k / 3) % 2));
      end else begin
        chk($sformatf("fair_m0_wait_%0d", k), m0_waitrequest, 1);
        chk($sformatf("fair_m1_wait_%0d", k), m1_waitrequest, 1);
      end
      step();
    end
    m0_read = 1'b0;
    m1_read = 1'b0;
    step();

    // m1 waits while its address wanders; grant-cycle address counts
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b0;
    push(1'b0, ID_WORD);
    push(1'b1, TS_WORD);
    @(negedge clock);
    chk("stab_m0_wait_T", m0_waitrequest, 0);
    step();
    m0_read = 1'b0;
    m1_address = 1'b1;
    step();
    m1_address = 1'b0;
    step();
    m1_address = 1'b1;
    @(negedge clock);
    chk("stab_m1_wait_T3", m1_waitrequest, 0);
    step();
    m1_read = 1'b0;
    m1_address = 1'b0;
    @(negedge clock);
    chk("stab_saddr_T4", s_address, 1);
    step();
    step();
    step();

    // reset during the capture cycle drops the read
    m1_read = 1'b1;
    m1_address = 1'b0;
    @(negedge clock);
    chk("rmid_m1_wait_T", m1_waitrequest, 0);
    step();
    m1_read = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("rmid_busy_T1", busy, 1);
    chk("rmid_m1_wait_T1", m1_waitrequest, 1);
    step();
    @(negedge clock);
    chk("rmid_m1_valid_T2", m1_readdatavalid, 0);
    chk("rmid_busy_T2", busy, 0);
    chk("rmid_m1_data_T2", m1_readdata, 0);
    step();
    reset_n = 1'b1;
    repeat (4) step();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
